// File: rtl/osd_spi_master.sv
// ============================================================================
// Module   : osd_spi_master
// Purpose  : SPI master that sends OSD enable/disable/write-line commands,
//            streaming 256 payload bytes from a synchronous RAM for writes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module osd_spi_master #(
    parameter int CLK_DIV = 4,
    parameter int GAP     = 8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_line,
    output logic       data_req,
    output logic [7:0] data_addr,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       SPI_SCK,
    output logic       SPI_SS3,
    output logic       SPI_DO
);

    localparam logic [7:0] c_DIV_M1 = 8'(CLK_DIV - 1);
    localparam logic [7:0] c_DIV_M2 = 8'(CLK_DIV - 2);
    localparam logic [7:0] c_GAP_M1 = 8'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SHIFT_LO = 3'd2,
        S_SHIFT_HI = 3'd3,
        S_TAIL     = 3'd4,
        S_GAP      = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_cnt;
    logic [2:0]  r_bit;
    logic [8:0]  r_bytecnt;
    logic        r_pending;
    logic        r_is_wr;
    logic [7:0]  r_shreg;
    logic [7:0]  r_hold;
    logic        r_req;
    logic        r_req_d1;
    logic [7:0]  r_addr;
    logic        r_sck;
    logic        r_ss3;
    logic        r_do;

    logic        w_phase_end;
    logic        w_last_bit;
    logic        w_more;
    logic [7:0]  w_cmd_byte;
    logic [7:0]  w_next_byte;

    assign w_phase_end = (r_cnt == 8'd0);
    assign w_last_bit  = (r_bit == 3'd7);
    assign w_more      = r_is_wr && (r_bytecnt != 9'd256);
    // With CLK_DIV = 2 the RAM data arrives on the same edge the byte loads.
    assign w_next_byte = r_req_d1 ? data_in : r_hold;

    always_comb begin
        w_cmd_byte = 8'h40;
        case (cmd_op)
            2'd1:    w_cmd_byte = 8'h41;
            2'd2:    w_cmd_byte = {5'b00100, cmd_line};
            default: w_cmd_byte = 8'h40;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (cmd_valid) w_next = (cmd_op == 2'd3) ? S_GAP : S_LOAD;
            S_LOAD:     w_next = S_SHIFT_LO;
            S_SHIFT_LO: if (w_phase_end) w_next = S_SHIFT_HI;
            S_SHIFT_HI: if (w_phase_end) w_next = (w_last_bit && !r_pending) ? S_TAIL : S_SHIFT_LO;
            S_TAIL:     if (w_phase_end) w_next = S_GAP;
            S_GAP:      if (w_phase_end) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_cnt     <= 8'd0;
            r_bit     <= 3'd0;
            r_bytecnt <= 9'd0;
            r_pending <= 1'b0;
            r_is_wr   <= 1'b0;
            r_shreg   <= 8'd0;
            r_hold    <= 8'd0;
            r_req     <= 1'b0;
            r_req_d1  <= 1'b0;
            r_addr    <= 8'd0;
            r_sck     <= 1'b0;
            r_ss3     <= 1'b1;
            r_do      <= 1'b0;
        end else begin
            r_sck    <= (w_next == S_SHIFT_HI);
            r_ss3    <= !((w_next == S_LOAD) || (w_next == S_SHIFT_LO) ||
                          (w_next == S_SHIFT_HI) || (w_next == S_TAIL));
            r_req    <= 1'b0;
            r_req_d1 <= r_req;
            if (r_req_d1) r_hold <= data_in;

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_cnt     <= (cmd_op == 2'd3) ? 8'd0 : c_DIV_M2;
                        r_bit     <= 3'd0;
                        r_bytecnt <= 9'd0;
                        r_pending <= 1'b0;
                        r_is_wr   <= (cmd_op == 2'd2);
                        if (cmd_op != 2'd3) begin
                            r_shreg <= w_cmd_byte;
                            r_do    <= w_cmd_byte[7];
                        end
                    end
                end
                S_SHIFT_LO: begin
                    if (w_phase_end) begin
                        r_cnt <= c_DIV_M1;
                        // Fetch the next payload byte while bit 0 is high.
                        if (w_last_bit && w_more) begin
                            r_req     <= 1'b1;
                            r_addr    <= r_bytecnt[7:0];
                            r_bytecnt <= r_bytecnt + 9'd1;
                            r_pending <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_SHIFT_HI: begin
                    if (w_phase_end) begin
                        r_cnt <= c_DIV_M1;
                        r_bit <= r_bit + 3'd1;
                        if (w_last_bit) begin
                            if (r_pending) begin
                                r_shreg   <= w_next_byte;
                                r_do      <= w_next_byte[7];
                                r_pending <= 1'b0;
                            end
                        end else begin
                            r_shreg <= {r_shreg[6:0], 1'b0};
                            r_do    <= r_shreg[6];
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_TAIL: begin
                    if (w_phase_end) begin
                        r_cnt <= c_GAP_M1;
                        r_do  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_GAP: begin
                    if (!w_phase_end) r_cnt <= r_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = !cmd_ready;
    assign data_req  = r_req;
    assign data_addr = r_addr;
    assign SPI_SCK   = r_sck;
    assign SPI_SS3   = r_ss3;
    assign SPI_DO    = r_do;

endmodule

`default_nettype wire

// File: tb/tb_osd_spi_master.sv
// ============================================================================
// Module   : tb_osd_spi_master
// Purpose  : Directed self-checking bench for osd_spi_master with SPI slave
//            and synchronous RAM models.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_osd_spi_master;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;

    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op    = 2'd0;
    logic [2:0] cmd_line  = 3'd0;
    logic       cmd_ready, data_req, busy, SPI_SCK, SPI_SS3, SPI_DO;
    logic [7:0] data_addr;
    logic [7:0] data_in = 8'hA5;

    logic       v2 = 1'b0;
    logic [1:0] op2 = 2'd0;
    logic [2:0] line2 = 3'd0;
    logic       ready2, req2, busy2, sck2, ss32, do2;
    logic [7:0] addr2;
    logic [7:0] din2 = 8'hA5;

    int checks = 0;
    int errors = 0;

    osd_spi_master #(.CLK_DIV(4), .GAP(8)) u_dut (
        .clk_sys(clk_sys), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_line(cmd_line), .data_req(data_req), .data_addr(data_addr),
        .data_in(data_in), .busy(busy), .SPI_SCK(SPI_SCK), .SPI_SS3(SPI_SS3), .SPI_DO(SPI_DO)
    );

    osd_spi_master #(.CLK_DIV(2), .GAP(3)) u_dut2 (
        .clk_sys(clk_sys), .reset(reset), .cmd_valid(v2), .cmd_ready(ready2),
        .cmd_op(op2), .cmd_line(line2), .data_req(req2), .data_addr(addr2),
        .data_in(din2), .busy(busy2), .SPI_SCK(sck2), .SPI_SS3(ss32), .SPI_DO(do2)
    );

    always #5 clk_sys = ~clk_sys;

    // SPI slave, RAM and protocol monitors for the CLK_DIV=4 instance.
    logic [7:0] cap1 [0:599];
    logic [7:0] req1 [0:599];
    int cap1_n = 0, req1_n = 0, nbit1 = 0, lowcnt1 = 0, last_low1 = 0;
    int hicnt1 = 0, last_hi1 = 0, falls1 = 0, viol_do1 = 0, viol_ss1 = 0;
    logic [7:0] sh1 = 8'd0;
    logic prev_sck1 = 1'b0, prev_do1 = 1'b0;

    always @(posedge clk_sys) begin
        prev_sck1 <= SPI_SCK;
        prev_do1  <= SPI_DO;
        if (SPI_SS3) begin
            nbit1   <= 0;
            lowcnt1 <= 0;
            if (lowcnt1 != 0) last_low1 <= lowcnt1;
            hicnt1  <= hicnt1 + 1;
            if (SPI_DO !== 1'b0) viol_ss1 <= viol_ss1 + 1;
        end else begin
            lowcnt1 <= lowcnt1 + 1;
            if (lowcnt1 == 0) falls1 <= falls1 + 1;
            if (hicnt1 != 0) last_hi1 <= hicnt1;
            hicnt1 <= 0;
            if (SPI_SCK && (SPI_DO !== prev_do1)) viol_do1 <= viol_do1 + 1;
            if (SPI_SCK && !prev_sck1) begin
                if (nbit1 == 7) begin
                    cap1[cap1_n] <= {sh1[6:0], SPI_DO};
                    cap1_n       <= cap1_n + 1;
                    nbit1        <= 0;
                end else begin
                    nbit1 <= nbit1 + 1;
                end
                sh1 <= {sh1[6:0], SPI_DO};
            end
        end
        if (data_req) begin
            req1[req1_n] <= data_addr;
            req1_n       <= req1_n + 1;
        end
        data_in <= data_req ? ~data_addr : 8'hA5;
    end

    // Same models for the CLK_DIV=2 instance.
    logic [7:0] cap2 [0:299];
    logic [7:0] req2a [0:299];
    int cap2_n = 0, req2_n = 0, nbit2 = 0, lowcnt2 = 0, last_low2 = 0;
    logic [7:0] sh2 = 8'd0;
    logic prev_sck2 = 1'b0;

    always @(posedge clk_sys) begin
        prev_sck2 <= sck2;
        if (ss32) begin
            nbit2   <= 0;
            lowcnt2 <= 0;
            if (lowcnt2 != 0) last_low2 <= lowcnt2;
        end else begin
            lowcnt2 <= lowcnt2 + 1;
            if (sck2 && !prev_sck2) begin
                if (nbit2 == 7) begin
                    cap2[cap2_n] <= {sh2[6:0], do2};
                    cap2_n       <= cap2_n + 1;
                    nbit2        <= 0;
                end else begin
                    nbit2 <= nbit2 + 1;
                end
                sh2 <= {sh2[6:0], do2};
            end
        end
        if (req2) begin
            req2a[req2_n] <= addr2;
            req2_n        <= req2_n + 1;
        end
        din2 <= req2 ? ~addr2 : 8'hA5;
    end

    task automatic send1(input logic [1:0] op, input logic [2:0] line);
        @(negedge clk_sys);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_line  = line;
        @(negedge clk_sys);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ready1(input int budget, output int gap, output bit ok);
        gap = 0;
        ok  = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_sys);
            if (busy && SPI_SS3) gap++;
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        checks++;
        if ({SPI_SS3, SPI_SCK, SPI_DO, data_req, busy, cmd_ready} !== 6'b100001) begin
            errors++;
            $display("FAIL reset_outputs: ss3/sck/do/req/busy/ready got %b expected 100001",
                     {SPI_SS3, SPI_SCK, SPI_DO, data_req, busy, cmd_ready});
        end
        checks++;
        if (data_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_addr: got %h expected 00", data_addr);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        checks++;
        if (cmd_ready !== 1'b1 || SPI_SS3 !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: ready %b ss3 %b expected 1 1", cmd_ready, SPI_SS3);
        end
    endtask

    task automatic test_enable();
        int base, gap;
        bit ok;
        base = cap1_n;
        @(negedge clk_sys);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_line = 3'd0;
        @(negedge clk_sys);
        cmd_valid = 1'b0;
        cmd_op    = 2'd2;
        checks++;
        if ({SPI_SS3, SPI_SCK, SPI_DO, busy} !== 4'b0001) begin
            errors++;
            $display("FAIL enable_first_cycle: ss3/sck/do/busy got %b expected 0001",
                     {SPI_SS3, SPI_SCK, SPI_DO, busy});
        end
        wait_ready1(2000, gap, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL enable_timeout: cmd_ready got 0 expected 1");
        end
        checks++;
        if (cap1_n !== base + 1 || cap1[base] !== 8'h41) begin
            errors++;
            $display("FAIL enable_byte: got %h (count %0d) expected 41 (count 1)",
                     cap1[base], cap1_n - base);
        end
        checks++;
        if (last_low1 !== 68) begin
            errors++;
            $display("FAIL enable_ss3_low: got %0d expected 68", last_low1);
        end
        checks++;
        if (gap !== 8) begin
            errors++;
            $display("FAIL enable_gap: got %0d expected 8", gap);
        end
    endtask

    task automatic test_write();
        int base, rbase, gap, bad, badaddr;
        bit ok;
        logic [7:0] kk;
        base  = cap1_n;
        rbase = req1_n;
        send1(2'd2, 3'd5);
        wait_ready1(20000, gap, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL write_timeout: cmd_ready got 0 expected 1");
        end
        checks++;
        if (cap1_n !== base + 257 || cap1[base] !== 8'h25) begin
            errors++;
            $display("FAIL write_cmd: got %h (bytes %0d) expected 25 (bytes 257)",
                     cap1[base], cap1_n - base);
        end
        bad = 0;
        badaddr = 0;
        for (int k = 0; k < 256; k++) begin
            kk = 8'(k);
            if (cap1[base + 1 + k] !== ~kk) bad++;
            if (req1[rbase + k] !== kk) badaddr++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL write_payload: got %0d wrong bytes expected 0", bad);
        end
        checks++;
        if (req1_n - rbase !== 256 || badaddr !== 0) begin
            errors++;
            $display("FAIL write_requests: got %0d reqs, %0d bad addrs expected 256, 0",
                     req1_n - rbase, badaddr);
        end
        checks++;
        if (last_low1 !== 16452) begin
            errors++;
            $display("FAIL write_ss3_low: got %0d expected 16452", last_low1);
        end
        checks++;
        if (data_addr !== 8'hFF) begin
            errors++;
            $display("FAIL write_addr_hold: got %h expected ff", data_addr);
        end
    endtask

    task automatic test_reset_mid();
        int base, gap;
        bit ok;
        base = cap1_n;
        send1(2'd2, 3'd1);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_sys);
            if (cap1_n >= base + 10 && SPI_SCK) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midreset_reach: byte 10 got not reached expected reached");
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({SPI_SS3, SPI_SCK, SPI_DO, data_req, busy, cmd_ready} !== 6'b100001 ||
            data_addr !== 8'h00) begin
            errors++;
            $display("FAIL midreset_async: ss3/sck/do/req/busy/ready %b addr %h expected 100001 00",
                     {SPI_SS3, SPI_SCK, SPI_DO, data_req, busy, cmd_ready}, data_addr);
        end
        @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        base = cap1_n;
        send1(2'd0, 3'd0);
        wait_ready1(2000, gap, ok);
        checks++;
        if (!ok || cap1_n !== base + 1 || cap1[base] !== 8'h40 || last_low1 !== 68) begin
            errors++;
            $display("FAIL midreset_disable: got %h (bytes %0d, low %0d) expected 40 (bytes 1, low 68)",
                     cap1[base], cap1_n - base, last_low1);
        end
    endtask

    task automatic test_op3();
        int f0, c0;
        f0 = falls1;
        c0 = cap1_n;
        @(negedge clk_sys);
        cmd_valid = 1'b1; cmd_op = 2'd3;
        @(negedge clk_sys);
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0 || SPI_SS3 !== 1'b1) begin
            errors++;
            $display("FAIL op3_busy: ready %b ss3 %b expected 0 1", cmd_ready, SPI_SS3);
        end
        @(negedge clk_sys);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL op3_ready: got %b expected 1", cmd_ready);
        end
        repeat (20) @(negedge clk_sys);
        checks++;
        if (falls1 !== f0 || cap1_n !== c0) begin
            errors++;
            $display("FAIL op3_no_spi: got %0d ss3 falls expected 0", falls1 - f0);
        end
    endtask

    task automatic test_back_to_back();
        int base, gap;
        bit ok;
        base = cap1_n;
        @(negedge clk_sys);
        cmd_valid = 1'b1; cmd_op = 2'd1;
        @(negedge clk_sys);
        cmd_op = 2'd0;
        wait_ready1(2000, gap, ok);
        @(negedge clk_sys);
        checks++;
        if (!ok || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_accept: busy got %b expected 1", busy);
        end
        cmd_valid = 1'b0;
        wait_ready1(2000, gap, ok);
        checks++;
        if (!ok || cap1_n !== base + 2 || cap1[base] !== 8'h41 || cap1[base + 1] !== 8'h40) begin
            errors++;
            $display("FAIL b2b_bytes: got %h %h (bytes %0d) expected 41 40 (bytes 2)",
                     cap1[base], cap1[base + 1], cap1_n - base);
        end
        checks++;
        if (last_hi1 < 8) begin
            errors++;
            $display("FAIL b2b_gap: got %0d ss3-high cycles expected >= 8", last_hi1);
        end
        checks++;
        if (viol_do1 !== 0 || viol_ss1 !== 0) begin
            errors++;
            $display("FAIL do_timing: got %0d do-while-sck-high, %0d do-while-ss3-high expected 0 0",
                     viol_do1, viol_ss1);
        end
    endtask

    task automatic test_div2();
        int bad, badaddr;
        bit ok;
        logic [7:0] kk;
        @(negedge clk_sys);
        v2 = 1'b1; op2 = 2'd2; line2 = 3'd0;
        @(negedge clk_sys);
        v2 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk_sys);
            if (ready2) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || cap2_n !== 257 || cap2[0] !== 8'h20) begin
            errors++;
            $display("FAIL div2_cmd: got %h (bytes %0d) expected 20 (bytes 257)", cap2[0], cap2_n);
        end
        bad = 0;
        badaddr = 0;
        for (int k = 0; k < 256; k++) begin
            kk = 8'(k);
            if (cap2[1 + k] !== ~kk) bad++;
            if (req2a[k] !== kk) badaddr++;
        end
        checks++;
        if (bad !== 0 || badaddr !== 0 || req2_n !== 256) begin
            errors++;
            $display("FAIL div2_payload: got %0d bad bytes, %0d bad addrs, %0d reqs expected 0, 0, 256",
                     bad, badaddr, req2_n);
        end
        checks++;
        if (last_low2 !== 8226) begin
            errors++;
            $display("FAIL div2_ss3_low: got %0d expected 8226", last_low2);
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_write();
        test_reset_mid();
        test_op3();
        test_back_to_back();
        test_div2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/osd_spi_master.md
OSD_SPI_MASTER -- requirements
Module: osd_spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, giving the SCK half-period in clk_sys cycles; legal range 2..255.
REQ-002 SHALL have parameter GAP, default 8, giving the minimum SPI_SS3-high clk_sys cycles between transactions; legal range 1..255.
REQ-003 clk_sys  in  1  system clock; all logic is on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  high only in IDLE; a command is accepted on cmd_valid && cmd_ready.
REQ-007 cmd_op  in  2  operation: 0 = disable, 1 = enable, 2 = write line, 3 = reserved.
REQ-008 cmd_line  in  3  OSD line (0..7) for a write.
REQ-009 data_req  out  1  one-cycle pulse requesting the payload byte at data_addr.
REQ-010 data_addr  out  8  payload byte index, 0..255.
REQ-011 data_in  in  8  payload byte, valid exactly 1 cycle after data_req (synchronous RAM read).
REQ-012 busy  out  1  equals !cmd_ready.
REQ-013 SPI_SCK  out  1  serial clock; idles low.
REQ-014 SPI_SS3  out  1  OSD chip select, active low; idles high.
REQ-015 SPI_DO  out  1  serial data, MSB first.

Function
REQ-016 SHALL capture cmd_op and cmd_line at acceptance; changes on the inputs afterwards SHALL have no effect.
REQ-017 Command byte SHALL be 0x40 for op 0, 0x41 for op 1, and {5'b00100, cmd_line} for op 2.
REQ-018 An op 3 command SHALL be accepted and dropped: no SPI activity, and cmd_ready SHALL return high on the cycle after acceptance.
REQ-019 States SHALL be IDLE -> LOAD -> SHIFT_LO <-> SHIFT_HI -> TAIL -> GAP -> IDLE.
REQ-020 On the cycle after acceptance (T+1), the block SHALL drive SPI_SS3 low, SPI_SCK low, and SPI_DO to bit 7 of the command byte.
REQ-021 Each bit SHALL be presented as CLK_DIV cycles with SCK low followed by CLK_DIV cycles with SCK high.
REQ-022 SPI_DO SHALL change only while SCK is low, on the first cycle of the low phase, so the receiver samples it on the rising SCK edge.
REQ-023 Bytes SHALL be contiguous; the next byte's bit 7 SHALL follow bit 0 of the previous byte without an extra gap.
REQ-024 For op 2, the block SHALL send 256 payload bytes after the command byte, in data_addr order 0, 1, ..., 255.
REQ-025 data_req for payload byte k SHALL pulse on the first SCK-high cycle of bit 0 of the preceding byte (the command byte when k = 0), with data_addr = k.
REQ-026 data_in SHALL be latched into a holding register on the following cycle.
REQ-027 data_addr SHALL hold its value until the next data_req.
REQ-028 The byte counter SHALL be 9 bits wide; data_addr SHALL be its low 8 bits and SHALL NOT wrap within a transaction.
REQ-029 After the high phase of the final bit, the block SHALL hold SCK low for CLK_DIV cycles (TAIL), then drive SPI_SS3 high.
REQ-030 GAP state SHALL keep SPI_SS3 high for GAP cycles; the cycle after GAP ends, cmd_ready SHALL assert.
REQ-031 SS3-low duration SHALL be N*16*CLK_DIV + CLK_DIV cycles, where N = 1 for ops 0/1 and N = 257 for op 2.
REQ-032 cmd_valid asserted while busy SHALL be ignored (not queued); a held cmd_valid is accepted on the first cmd_ready cycle.
REQ-033 SPI_DO SHALL be 0 whenever SPI_SS3 is high.

Reset
REQ-034 Reset SHALL immediately (asynchronously) force IDLE, SPI_SS3 = 1, SPI_SCK = 0, SPI_DO = 0, data_req = 0, data_addr = 0, busy = 0, cmd_ready = 1, including mid-transaction.
REQ-035 After reset release, the first accepted command SHALL produce a complete, well-formed transaction; no residue of an aborted transfer SHALL appear.

Verification
REQ-036 Enable, CLK_DIV = 4 -> SPI slave model captures 0x41; SS3 low for 68 cycles; cmd_ready high 8 cycles after SS3 rises.
REQ-037 Write line 5 with data_in = ~addr -> slave captures 0x25 then bytes 0xFF, 0xFE, ..., 0x00; 256 data_req pulses with ascending data_addr; SS3 low for 16452 cycles.
REQ-038 Reset asserted during byte 10 of a write -> same-cycle SS3 = 1, SCK = 0, DO = 0; a subsequent disable captures 0x40 exactly.
REQ-039 op 3 -> no SS3 activity; cmd_ready low for 1 cycle only.
REQ-040 cmd_valid held high with op 1, then op 0 -> two transactions separated by at least GAP SS3-high cycles; cmd_op change during the first transaction does not alter its byte.
REQ-041 CLK_DIV = 2 write -> data_in latched before the byte is loaded; no byte skipped or duplicated.
